// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// scan FSM states, the blank segment pattern, the active-low hex font
// and the per-digit record stored in the image buffers.
package seven_seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // All segments off (active-low bus).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex font, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
  } digit_t;

endpackage

// File: rtl/seven_seg_scan_controller_if.sv
// Write/commit port of the scan controller. The datapath side is the
// master; the controller is the slave and reports a pending commit back.
interface seven_seg_scan_controller_if #(
  parameter int N_DIGITS = 8
);

  localparam int AW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic          commit;
  logic          commit_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, commit,
    input  commit_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, commit,
    output commit_busy
  );

endinterface

// File: rtl/seven_seg_scan_controller_hex_to_seg7.sv
// Combinational nibble to active-low segment lookup. The controller
// registers the result together with the anode and dp outputs.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_FONT[i_nibble];

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Eight-digit seven-segment scan controller. A shadow image is written
// through the write port and copied into the scanned display image at a
// frame boundary after a commit. Each digit slot starts with a blanking
// interval (all anodes off) to suppress ghosting, then drives the digit.
// Internal counters describe the cycle about to be shown; the outputs are
// registered from them, so segments, dp and anodes always switch together.
module seven_seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                      clck,
  input  logic                      reset,
  seven_seg_scan_controller_if.slave wr_bus,
  input  logic [N_DIGITS-1:0]       digit_en,
  output logic [6:0]                a_to_g,
  output logic                      dp,
  output logic [N_DIGITS-1:0]       Anode_Activate,
  output logic                      frame_start
);

  localparam int AW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0]  LP_CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]  LP_CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  LP_CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  LP_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0]  LP_IDX_ZERO   = AW'(0);
  localparam logic [AW-1:0]  LP_IDX_ONE    = AW'(1);
  localparam logic [AW-1:0]  LP_IDX_LAST   = AW'(N_DIGITS - 1);
  localparam logic [AW1-1:0] LP_N_DIGITS   = AW1'(N_DIGITS);

  // Scan position of the next displayed cycle
  scan_state_t   r_state;
  scan_state_t   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;
  logic          w_frame_wrap;

  // Image buffers and commit tracking
  digit_t r_shadow      [N_DIGITS];
  digit_t r_display     [N_DIGITS];
  digit_t w_shadow_next [N_DIGITS];
  digit_t w_cur_digit;
  logic   r_commit_pending;
  logic   w_wr_hit;
  logic   w_do_copy;

  // Output stage
  logic [6:0]          w_seg_lut;
  logic [6:0]          w_seg_next;
  logic                w_dp_next;
  logic [N_DIGITS-1:0] w_anode_next;
  logic                w_fs_next;
  logic [6:0]          r_a_to_g;
  logic                r_dp;
  logic [N_DIGITS-1:0] r_anode;
  logic                r_frame_start;

  assign w_wr_hit    = wr_bus.wr_en && ({1'b0, wr_bus.wr_addr} < LP_N_DIGITS);
  assign w_do_copy   = w_frame_wrap && (r_commit_pending || wr_bus.commit);
  assign w_cur_digit = r_display[r_idx];

  hex_to_seg7 u_font (
    .i_nibble (w_cur_digit.nibble),
    .o_seg    (w_seg_lut)
  );

  // Scan state, slot counter and digit index registers
  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      r_state <= BLANK;
      r_cnt   <= LP_CNT_ZERO;
      r_idx   <= LP_IDX_ZERO;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next scan position: blank then drive within each slot, wrap per frame
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + LP_CNT_ONE;
    w_idx_next   = r_idx;
    w_frame_wrap = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == LP_BLANK_LAST) begin
          w_state_next = DRIVE;
        end else begin
          w_state_next = BLANK;
        end
      end
      DRIVE: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_state_next = BLANK;
          w_cnt_next   = LP_CNT_ZERO;
          if (r_idx == LP_IDX_LAST) begin
            w_idx_next   = LP_IDX_ZERO;
            w_frame_wrap = 1'b1;
          end else begin
            w_idx_next = r_idx + LP_IDX_ONE;
          end
        end else begin
          w_state_next = DRIVE;
        end
      end
      default: begin
        w_state_next = BLANK;
        w_cnt_next   = LP_CNT_ZERO;
        w_idx_next   = LP_IDX_ZERO;
      end
    endcase
  end

  // Shadow image with this cycle's write applied, so a boundary copy sees it
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_wr_hit && (wr_bus.wr_addr == AW'(i))) begin
        w_shadow_next[i] = '{nibble: wr_bus.wr_data, dp: wr_bus.wr_dp};
      end else begin
        w_shadow_next[i] = r_shadow[i];
      end
    end
  end

  // Buffers and commit flag: copy shadow to display at the frame boundary
  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_shadow[i]  <= '{nibble: 4'h0, dp: 1'b0};
        r_display[i] <= '{nibble: 4'h0, dp: 1'b0};
      end
      r_commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_shadow[i] <= w_shadow_next[i];
        if (w_do_copy) begin
          r_display[i] <= w_shadow_next[i];
        end
      end
      if (w_frame_wrap) begin
        r_commit_pending <= 1'b0;
      end else if (wr_bus.commit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

  // Pin values for the scan position about to be shown
  always_comb begin
    w_anode_next = {N_DIGITS{1'b1}};
    w_seg_next   = SEG_BLANK;
    w_dp_next    = 1'b1;
    w_fs_next    = (r_idx == LP_IDX_ZERO) && (r_cnt == LP_CNT_ZERO);
    if (r_state == DRIVE) begin
      w_seg_next = w_seg_lut;
      w_dp_next  = ~w_cur_digit.dp;
      if (digit_en[r_idx]) begin
        w_anode_next[r_idx] = 1'b0;
      end else begin
        w_anode_next = {N_DIGITS{1'b1}};
      end
    end else begin
      w_anode_next = {N_DIGITS{1'b1}};
    end
  end

  // Output registers: segments, dp and anodes update on the same edge
  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      r_a_to_g      <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_anode       <= {N_DIGITS{1'b1}};
      r_frame_start <= 1'b0;
    end else begin
      r_a_to_g      <= w_seg_next;
      r_dp          <= w_dp_next;
      r_anode       <= w_anode_next;
      r_frame_start <= w_fs_next;
    end
  end

  assign a_to_g             = r_a_to_g;
  assign dp                 = r_dp;
  assign Anode_Activate     = r_anode;
  assign frame_start        = r_frame_start;
  assign wr_bus.commit_busy = r_commit_pending;

endmodule

// File: doc/seven_seg_scan_controller.md
# seven_seg_scan_controller

- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Holds a double-buffered digit/decimal-point image loaded through a simple write port.
- Sequences the common anodes one digit at a time, with a programmable refresh slot and ghost-suppression blanking.
- Drives the shared active-low segment bus (a_to_g, dp); sits between the counter/datapath logic and the board pins.

## Interface
Parameters:
- N_DIGITS, 8, digits scanned; width of Anode_Activate.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clck  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; always accepted (no backpressure).
- wr_addr  in  $clog2(N_DIGITS)  digit index written.
- wr_data  in  4  hex nibble for that digit.
- wr_dp  in  1  decimal point for that digit (1 = lit).
- digit_en  in  N_DIGITS  per-digit enable mask; sampled live.
- commit  in  1  request to copy shadow image to display image at next frame boundary.
- a_to_g  out  7  segments, active-low; bit 6 = a … bit 0 = g.
- dp  out  1  decimal point, active-low.
- Anode_Activate  out  N_DIGITS  anodes, active-low, at most one low.
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.
- commit_busy  out  1  high while a commit is pending.

## Operation
- **Buffers.** Two buffers: shadow (written by the port) and display (scanned). Each holds N_DIGITS × {nibble, dp}. Both reset to 0 / dp 0.
- **Writes.** wr_en updates shadow[wr_addr] on the next edge. wr_addr ≥ N_DIGITS is ignored.
- **Commit.** Sets commit_pending. At a frame boundary with commit_pending or commit high, the whole shadow is copied into display and commit_pending clears.
  - A write in the boundary cycle is forwarded into the copy.
  - A commit in the boundary cycle is applied immediately; commit_busy never rises.
  - Repeated commits while pending are a no-op.
- **Frame boundary.** The edge where the slot counter wraps at the last cycle of digit N_DIGITS-1.
- **Scan FSM.** State typedef scan_state_t with two states, BLANK and DRIVE.
  - BLANK: Anode_Activate all ones; a_to_g = 7'h7F; dp = 1. Lasts BLANK_CYCLES cycles, then goes to DRIVE.
  - DRIVE: Anode_Activate[idx] = 0 if digit_en[idx], else all ones. a_to_g = decode(display[idx].nibble); dp = ~display[idx].dp. Lasts REFRESH_DIV-BLANK_CYCLES cycles, then goes to BLANK with idx+1.
  - idx wraps N_DIGITS-1 → 0.
  - A disabled digit still consumes its slot, so brightness stays constant.
- **Decode.** Standard hex font 0–F, active-low. Examples: 0 → 7'b0000001, 8 → 7'b0000000, F → 7'b0111000.

## Timing
- **Counters.** Slot counter is $clog2(REFRESH_DIV) bits and counts 0..REFRESH_DIV-1. BLANK ↔ DRIVE switches when the counter reaches BLANK_CYCLES-1 or REFRESH_DIV-1.
- **Registered outputs.** All outputs are registered. Segment, anode and dp change on the same edge; there is never a cycle with an anode low and stale segments.
- **Reset values.** Asserting reset (async, any cycle, including mid-slot or while a commit is pending) forces:
  - state BLANK, idx 0, counter 0;
  - Anode_Activate all ones, a_to_g 7'h7F, dp 1;
  - frame_start 0, commit_busy 0, both buffers cleared.
- **Release from reset.** The first cycle after deassertion is slot 0 cycle 0; frame_start pulses there.
- **Write latency.** A write reaches the pins only after a commit and the next frame boundary. Worst case is N_DIGITS·REFRESH_DIV + 1 cycles from commit.
- **digit_en.** Takes effect on the next edge (no buffering).

## Structure
- **Package seven_seg_pkg:**
  - scan_state_t;
  - the SEG_BLANK constant (7'h7F);
  - the 16-entry active-low hex font constant array;
  - the digit record typedef {nibble, dp}.
- **Sub-module hex_to_seg7:** combinational nibble → a_to_g lookup using the package font. Its output is registered in the controller.
- **Remaining logic:** slot counter, digit index, FSM, buffers and commit logic all live in the top module.

## Test plan
Bench parameters: REFRESH_DIV=4, BLANK_CYCLES=1, N_DIGITS=8, which gives a 32-cycle frame.
1. **Reset mid-DRIVE.**
   - Stimulus: assert reset on cycle 13.
   - Required: outputs go to FF / 7F / 1 without waiting for a clock edge. After release, frame_start pulses on the first cycle and Anode_Activate = FE on the second cycle.
2. **Write and commit.**
   - Stimulus: write digits 0–7 = 0..7 with dp on digit 3, then commit.
   - Required: commit_busy high until the boundary. In the next frame, the digit 3 slot shows a_to_g = 7'b0000110 with dp = 0; digit 0 shows 7'b0000001.
3. **Write without commit.**
   - Stimulus: write digit 2 = F and never commit.
   - Required: display unchanged for 3 frames. After a commit, digit 2 shows 7'b0111000.
4. **Boundary-cycle write and commit.**
   - Stimulus: assert write and commit in the boundary cycle.
   - Required: the new value appears in the immediately following frame; commit_busy stays 0.
5. **Disabled digit.**
   - Stimulus: digit_en = 8'hF7.
   - Required: Anode_Activate stays FF for all of slot 3. Slot timing is unchanged: digit 4 is driven at the same cycle as with all digits enabled.
6. **Ghost and one-hot checks over 1000 frames.**
   - Every slot begins with exactly 1 blank cycle.
   - Anode_Activate is never anything other than all-ones or one-cold.
